result_collector: RTL and testbench
===================================

// Module: result_collector
// PURPOSE
//   Many-to-one counterpart of the result router: merges result codes from four
//   producer channels into one buffered stream for a single consumer.
//   Each cycle it arbitrates among valid channels and pushes one winner into a
//   DEPTH-entry FWFT FIFO, tagged with its source index.
//   Sits between the per-unit result generators and the downstream result sink.
// PARAMETERS
//   SIZE   5  width of a result code (bits)
//   DEPTH  4  FIFO entries; power of 2, >=2
// PORTS
//   clk        in   1                 rising-edge clock
//   rst_n      in   1                 async active-low reset
//   in_valid   in   4                 bit i: channel i offers in_data_i
//   in_data1   in   SIZE              channel 0 result code
//   in_data2   in   SIZE              channel 1 result code
//   in_data3   in   SIZE              channel 2 result code
//   in_data4   in   SIZE              channel 3 result code
//   in_ready   out  4                 one-hot grant; channel i transfers on valid&ready
//   out_valid  out  1                 FIFO head valid
//   out_data   out  SIZE              FIFO head result code
//   out_src    out  2                 FIFO head source index 0..3
//   out_ready  in   1                 consumer accepts head
//   count      out  $clog2(DEPTH)+1   occupancy 0..DEPTH
//   full       out  1                 count==DEPTH
// BEHAVIOUR
//   - Reset (async, rst_n=0): count=0, rd/wr ptrs=0, rr pointer=3 (ch0 wins first),
//     out_valid=0, out_data=0, out_src=0, full=0, in_ready=0.
//   - Grant: combinational from in_valid, full and arbitration state; at most one
//     in_ready bit high; all zero when full or in_valid==0. Never depends on in_ready.
//   - Push: valid&ready of granted ch -> store {src,data} at wr_ptr, wr_ptr++ (mod DEPTH).
//   - Pop: out_valid&out_ready -> rd_ptr++ (mod DEPTH).
//   - FWFT: pushed entry appears on out_* the cycle after the push edge (1-cycle latency).
//   - out_data/out_src = 0 while empty; never X/Z.
//     in_data_i ignored (may be X/Z) when in_valid[i]=0.
//   - Simultaneous push+pop: count unchanged, both ptrs advance.
//     Full blocks push even if a pop happens the same cycle (no same-cycle reuse).
//   - Pop when empty / push when full: impossible by handshake; state unchanged.
//   - Pointer wrap: DEPTH-1 -> 0, no bubble; count saturates logic at 0..DEPTH.
//   - Ungranted channels hold their data; the collector never drops an offered value.
//   - Reset mid-operation: all contents discarded, state as above immediately.
// CONFIGURATION
//   RESULT_COLLECTOR_RR_EN defined: round-robin; search starts at (last_grant+1)
//     mod 4, last_grant updated only on an actual push.
//   Undefined: fixed priority ch0 > ch1 > ch2 > ch3; no rr register.
// TESTING
//   1 Reset: rst_n=0 mid-traffic -> out_valid=0, count=0, in_ready=0 same cycle.
//   2 Single: in_valid=4'b0100, in_data3=5'd3, out_ready=1 -> in_ready=4'b0100;
//     next cycle out_valid=1, out_data=3, out_src=2; count back to 0 after pop.
//   3 Full: out_ready=0, in_valid=4'b0001 for 5 cycles -> count=4, full=1, in_ready=0
//     on 5th cycle; then out_ready=1 drains 4 entries in order, wrap clean.
//   4 Contention RR_EN: in_valid=4'b1111 held, out_ready=1 ->
//     out_src sequence 0,1,2,3,0.
//   5 Contention no macro: same stimulus -> out_src 0,0,0,0; ch1..3 starve.
//   6 Push+pop at count=2: one push, one pop same cycle -> count stays 2, order kept.

Source files
------------

// File: rtl/result_collector.sv
// Purpose: merges result codes from four producer channels into one FWFT FIFO tagged with source index.
// Latency: a granted value appears on out_* one cycle after its push edge.
// Backpressure: out_ready stalls the FIFO head; in_ready is withheld while full and ungranted channels hold.
//
// Ports: clk, rst_n (async active-low); in_valid[3:0] with in_data1..in_data4
// (channels 0..3) and one-hot in_ready grant; out_valid/out_data/out_src/out_ready
// head handshake; count (occupancy 0..DEPTH) and full status.
// Build option: define RESULT_COLLECTOR_RR_EN for round-robin arbitration;
// otherwise fixed priority ch0 > ch1 > ch2 > ch3.
module result_collector #(
    parameter int SIZE  = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [3:0]                 in_valid,
    input  logic [SIZE-1:0]            in_data1,
    input  logic [SIZE-1:0]            in_data2,
    input  logic [SIZE-1:0]            in_data3,
    input  logic [SIZE-1:0]            in_data4,
    output logic [3:0]                 in_ready,
    output logic                       out_valid,
    output logic [SIZE-1:0]            out_data,
    output logic [1:0]                 out_src,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [1:0]      src;
        logic [SIZE-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;
    logic [3:0]      grant;
    logic [1:0]      grant_idx;
    logic [SIZE-1:0] grant_data;
    logic            push;
    logic            pop;

    assign full      = (count_q == CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign in_ready  = grant;

    // Grant only exists for a valid channel, so any grant bit is a push.
    assign push = |grant;
    assign pop  = out_valid & out_ready;

`ifdef RESULT_COLLECTOR_RR_EN
    logic [1:0] last_grant;
    logic [1:0] cand;

    // Search starts just after the last channel that actually pushed.
    // rst_n gates the grant so in_ready reads 0 throughout reset.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        if (rst_n && !full) begin
            for (int i = 1; i <= 4; i++) begin
                cand = last_grant + 2'(i);
                if (in_valid[cand] && (grant == '0)) begin
                    grant[cand] = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    // Reset value 3 makes channel 0 the first winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 2'd3;
        end else if (push) begin
            last_grant <= grant_idx;
        end
    end
`else
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        if (rst_n && !full) begin
            if (in_valid[0]) begin
                grant     = 4'b0001;
                grant_idx = 2'd0;
            end else if (in_valid[1]) begin
                grant     = 4'b0010;
                grant_idx = 2'd1;
            end else if (in_valid[2]) begin
                grant     = 4'b0100;
                grant_idx = 2'd2;
            end else if (in_valid[3]) begin
                grant     = 4'b1000;
                grant_idx = 2'd3;
            end
        end
    end
`endif

    always_comb begin
        case (grant_idx)
            2'd0:    grant_data = in_data1;
            2'd1:    grant_data = in_data2;
            2'd2:    grant_data = in_data3;
            default: grant_data = in_data4;
        endcase
    end

    // Storage carries no reset; the empty-gated output mux keeps stale or
    // uninitialised entries from ever reaching out_*.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{src: grant_idx, data: grant_data};
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural AW-bit overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign out_data = out_valid ? mem[rd_ptr].data : '0;
    assign out_src  = out_valid ? mem[rd_ptr].src  : '0;

endmodule

// File: tb/tb_result_collector.sv
// Purpose: self-checking scoreboard bench for result_collector.
// Latency: model expects each push on out_* one cycle after its push edge.
// Backpressure: model withholds grants while its queue holds DEPTH entries.
module tb_result_collector;

    localparam int SIZE  = 5;
    localparam int DEPTH = 4;

    logic            clk;
    logic            rst_n;
    logic [3:0]      in_valid;
    logic [SIZE-1:0] in_data1, in_data2, in_data3, in_data4;
    logic [3:0]      in_ready;
    logic            out_valid;
    logic [SIZE-1:0] out_data;
    logic [1:0]      out_src;
    logic            out_ready;
    logic [2:0]      count;
    logic            full;

    result_collector #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .in_data4  (in_data4),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .count     (count),
        .full      (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Scoreboard entries are {src, data}.
    logic [SIZE+1:0] sb[$];
    logic [1:0]      pop_log[$];
    logic [SIZE-1:0] ch_data[4];
    logic [1:0]      tb_last = 2'd3;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_grant();
        logic [3:0] g;
        logic [1:0] c;
        g = '0;
        if (rst_n && sb.size() < DEPTH) begin
`ifdef RESULT_COLLECTOR_RR_EN
            for (int i = 1; i <= 4; i++) begin
                c = tb_last + 2'(i);
                if (in_valid[c] && g == '0) g[c] = 1'b1;
            end
`else
            c = '0;
            for (int i = 3; i >= 0; i--) begin
                if (in_valid[i]) begin
                    g = '0;
                    g[i] = 1'b1;
                end
            end
`endif
        end
        return g;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] g);
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    // Called at a falling edge with in_valid/out_ready already driven.
    task automatic cycle();
        logic [3:0] eg;
        logic       popped;
        logic [1:0] gi;
        in_data1 = ch_data[0];
        in_data2 = ch_data[1];
        in_data3 = ch_data[2];
        in_data4 = ch_data[3];
        #1;
        eg = model_grant();
        check("in_ready", 32'(in_ready), 32'(eg));
        if (sb.size() > 0) begin
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_data", 32'(out_data), 32'(sb[0][SIZE-1:0]));
            check("out_src", 32'(out_src), 32'(sb[0][SIZE+1:SIZE]));
        end else begin
            check("out_valid_empty", 32'(out_valid), 32'd0);
            check("out_data_empty", 32'(out_data), 32'd0);
            check("out_src_empty", 32'(out_src), 32'd0);
        end
        check("count", 32'(count), 32'(sb.size()));
        check("full", 32'(full), 32'(sb.size() == DEPTH));
        popped = out_ready && (sb.size() > 0);
        gi = onehot_idx(eg);
        @(posedge clk);
        if (popped) begin
            pop_log.push_back(sb[0][SIZE+1:SIZE]);
            void'(sb.pop_front());
        end
        if (eg != '0) begin
            sb.push_back({gi, ch_data[gi]});
            tb_last = gi;
            ch_data[gi] = SIZE'($urandom);
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [3:0] v, input logic ordy, input int n);
        for (int k = 0; k < n; k++) begin
            in_valid  = v;
            out_ready = ordy;
            cycle();
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) ch_data[i] = SIZE'($urandom);
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        in_data1 = '0; in_data2 = '0; in_data3 = '0; in_data4 = '0;
        @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_src", 32'(out_src), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        in_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;

        // Single transfer from channel 2.
        ch_data[2] = 5'd3;
        in_valid   = 4'b0100;
        out_ready  = 1'b1;
        in_data3   = ch_data[2];
        #1;
        check("single_grant", 32'(in_ready), 32'b0100);
        #1;
        cycle();
        in_valid = 4'b0000;
        #1;
        check("single_out_valid", 32'(out_valid), 32'd1);
        check("single_out_data", 32'(out_data), 32'd3);
        check("single_out_src", 32'(out_src), 32'd2);
        #1;
        cycle();
        check("single_count_after_pop", 32'(count), 32'd0);

        // Fill to full, then drain through the pointer wrap.
        run(4'b0001, 1'b0, 5);
        #1;
        check("full_count", 32'(count), 32'd4);
        check("full_flag", 32'(full), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        // Full blocks a push even when a pop happens the same cycle.
        run(4'b0001, 1'b1, 1);
        check("full_pop_count", 32'(count), 32'd3);
        run(4'b0000, 1'b1, 4);
        check("drained_count", 32'(count), 32'd0);

        // Simultaneous push and pop at count 2.
        run(4'b0010, 1'b0, 2);
        check("pp_count_pre", 32'(count), 32'd2);
        run(4'b1000, 1'b1, 1);
        check("pp_count_post", 32'(count), 32'd2);
        run(4'b0000, 1'b1, 3);

        // Reset in the middle of traffic.
        run(4'b1111, 1'b0, 3);
        in_valid = 4'b1111;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        tb_last = 2'd3;
        @(negedge clk);
        rst_n = 1'b1;

        // Contention on all four channels with a free-running consumer.
        pop_log.delete();
        run(4'b1111, 1'b1, 6);
        check("contention_pops", 32'(pop_log.size()), 32'd5);
        if (pop_log.size() >= 5) begin
`ifdef RESULT_COLLECTOR_RR_EN
            check("rr_src0", 32'(pop_log[0]), 32'd0);
            check("rr_src1", 32'(pop_log[1]), 32'd1);
            check("rr_src2", 32'(pop_log[2]), 32'd2);
            check("rr_src3", 32'(pop_log[3]), 32'd3);
            check("rr_src4", 32'(pop_log[4]), 32'd0);
`else
            check("fp_src0", 32'(pop_log[0]), 32'd0);
            check("fp_src1", 32'(pop_log[1]), 32'd0);
            check("fp_src2", 32'(pop_log[2]), 32'd0);
            check("fp_src3", 32'(pop_log[3]), 32'd0);
            check("fp_src4", 32'(pop_log[4]), 32'd0);
`endif
        end
        run(4'b0000, 1'b1, 3);
        check("final_count", 32'(count), 32'd0);

        // Random mixed traffic against the scoreboard.
        for (int k = 0; k < 200; k++) begin
            run(4'($urandom), 1'($urandom_range(0, 3) != 0), 1);
        end
        run(4'b0000, 1'b1, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
